// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with N combinational read ports,
//               optional write-to-read bypass, asynchronous clear and a
//               per-register busy scoreboard for decode-stage RAW stalls.
//               Register 0 is hardwired to zero and is never busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int NUM_REGISTERS = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1,
  parameter int ADDR_W        = $clog2(NUM_REGISTERS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]     ra,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              wa,
  input  logic [DATA_WIDTH-1:0]          wd,
  input  logic                           iv,
  input  logic [ADDR_W-1:0]              ia,
  output logic [ADDR_W:0]                busy_cnt
);

  logic [DATA_WIDTH-1:0]    regs [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy;
  logic [NUM_REGISTERS-1:0] busy_nxt;
  logic [ADDR_W:0]          cnt_nxt;

  // Next busy vector: writeback retires the producer, then a same-edge issue
  // re-marks it so the newest producer wins. Register 0 can never be busy.
  always_comb begin
    busy_nxt = busy;
    if (we && (wa != '0)) busy_nxt[wa] = 1'b0;
    if (iv && (ia != '0)) busy_nxt[ia] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector so busy_cnt tracks busy exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // Scoreboard state: busy bits and their count, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Register storage; writes to register 0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports: zero for register 0, forwarded write data on a bypass hit,
  // otherwise the stored value. Bypass is suppressed while reset is held so
  // every read port shows zero during reset.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = ra[k*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && rst_n && we && (wa == addr);
    assign rd[k*DATA_WIDTH +: DATA_WIDTH] = (addr == '0) ? '0 :
                                            hit          ? wd : regs[addr];
    assign rbusy[k] = (addr == '0) ? 1'b0 :
                      hit          ? 1'b0 : busy[addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb. One instance built with
//               bypass, one without, sharing all inputs. Stimulus pushes
//               hand-computed expectations; a negedge monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  // Expectation kinds
  localparam int K_RD  = 0;
  localparam int K_BSY = 1;
  localparam int K_CNT = 2;
  // Instance selectors
  localparam int D_BYP = 0;
  localparam int D_NOB = 1;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NP*AW-1:0] ra;
  logic             we;
  logic [AW-1:0]    wa;
  logic [DW-1:0]    wd;
  logic             iv;
  logic [AW-1:0]    ia;

  logic [NP*DW-1:0] rd_b, rd_n;
  logic [NP-1:0]    rbusy_b, rbusy_n;
  logic [AW:0]      cnt_b, cnt_n;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_sb #(.NUM_REGISTERS(NR), .DATA_WIDTH(DW), .NUM_READ(NP), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .we(we), .wa(wa), .wd(wd), .iv(iv), .ia(ia), .busy_cnt(cnt_b)
  );

  regfile_sb #(.NUM_REGISTERS(NR), .DATA_WIDTH(DW), .NUM_READ(NP), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
    .we(we), .wa(wa), .wd(wd), .iv(iv), .ia(ia), .busy_cnt(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch the observed value named by an expectation record.
  function automatic logic [31:0] actual(input exp_t e);
    logic [NP*DW-1:0] rdv;
    logic [NP-1:0]    bv;
    logic [AW:0]      cv;
    rdv = (e.dut == D_BYP) ? rd_b    : rd_n;
    bv  = (e.dut == D_BYP) ? rbusy_b : rbusy_n;
    cv  = (e.dut == D_BYP) ? cnt_b   : cnt_n;
    case (e.kind)
      K_RD:    actual = rdv[e.port*DW +: DW];
      K_BSY:   actual = {31'd0, bv[e.port]};
      default: actual = {26'd0, cv};
    endcase
  endfunction

  // Monitor: drain all expectations queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s (dut %0d): got %h expected %h", e.name, e.dut, a, e.exp);
      end
    end
  end

  task automatic expect_one(input string n, input int d, input int k, input int p,
                            input logic [31:0] v);
    exp_t e;
    e.name = n; e.dut = d; e.kind = k; e.port = p; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_both(input string n, input int k, input int p, input logic [31:0] v);
    expect_one(n, D_BYP, k, p, v);
    expect_one(n, D_NOB, k, p, v);
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0; iv = 1'b0; wa = '0; ia = '0; wd = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0; iv = 1'b0; ia = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state on address 0 and 5
    step(); set_ra(5'd0, 5'd5);
    expect_both("rst_rd0", K_RD, 0, 32'h0);
    expect_both("rst_rd1", K_RD, 1, 32'h0);
    expect_both("rst_bsy0", K_BSY, 0, 32'h0);
    expect_both("rst_bsy1", K_BSY, 1, 32'h0);
    expect_both("rst_cnt", K_CNT, 0, 32'h0);

    // Issue reg 3: not visible on rbusy in the issuing cycle
    step(); set_ra(5'd3, 5'd5); iv = 1'b1; ia = 5'd3;
    expect_both("iss_same_bsy", K_BSY, 0, 32'h0);
    expect_both("iss_same_cnt", K_CNT, 0, 32'h0);

    step(); set_ra(5'd3, 5'd3);
    expect_both("iss_bsy0", K_BSY, 0, 32'h1);
    expect_both("iss_bsy1", K_BSY, 1, 32'h1);
    expect_both("iss_cnt", K_CNT, 0, 32'h1);

    // Writeback reg 3 with a same-cycle read
    step(); set_ra(5'd3, 5'd0); we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
    expect_one("byp_rd", D_BYP, K_RD, 0, 32'hDEAD_BEEF);
    expect_one("byp_bsy", D_BYP, K_BSY, 0, 32'h0);
    expect_one("nob_rd_old", D_NOB, K_RD, 0, 32'h0);
    expect_one("nob_bsy_old", D_NOB, K_BSY, 0, 32'h1);
    expect_both("wb_cnt_same", K_CNT, 0, 32'h1);

    step(); set_ra(5'd3, 5'd0);
    expect_both("wb_rd_next", K_RD, 0, 32'hDEAD_BEEF);
    expect_both("wb_bsy_next", K_BSY, 0, 32'h0);
    expect_both("wb_cnt_next", K_CNT, 0, 32'h0);

    // Reg 4 old/new value around a write, no prior issue
    step(); we = 1'b1; wa = 5'd4; wd = 32'h1111_1111;
    step(); set_ra(5'd0, 5'd4); we = 1'b1; wa = 5'd4; wd = 32'h2222_2222;
    expect_one("nob_rd1_old", D_NOB, K_RD, 1, 32'h1111_1111);
    expect_one("byp_rd1_new", D_BYP, K_RD, 1, 32'h2222_2222);
    expect_both("noissue_cnt", K_CNT, 0, 32'h0);
    step(); set_ra(5'd0, 5'd4);
    expect_both("rd1_next", K_RD, 1, 32'h2222_2222);
    expect_both("noissue_bsy", K_BSY, 1, 32'h0);

    // Same-edge issue and write to reg 7: data written, still busy
    step(); iv = 1'b1; ia = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'hA5A5_0000;
    step(); set_ra(5'd7, 5'd7);
    expect_both("iw_rd0", K_RD, 0, 32'hA5A5_0000);
    expect_both("iw_rd1", K_RD, 1, 32'hA5A5_0000);
    expect_both("iw_bsy0", K_BSY, 0, 32'h1);
    expect_both("iw_bsy1", K_BSY, 1, 32'h1);
    expect_both("iw_cnt", K_CNT, 0, 32'h1);

    // Write and issue to register 0 are ignored
    step(); set_ra(5'd0, 5'd0); we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    iv = 1'b1; ia = 5'd0;
    expect_both("r0_rd_same", K_RD, 0, 32'h0);
    expect_both("r0_bsy_same", K_BSY, 1, 32'h0);
    step(); set_ra(5'd0, 5'd0);
    expect_both("r0_rd", K_RD, 0, 32'h0);
    expect_both("r0_bsy", K_BSY, 0, 32'h0);
    expect_both("r0_cnt", K_CNT, 0, 32'h1);

    // Write data presented with we=0 is not stored
    step(); we = 1'b0; wa = 5'd2; wd = 32'h1234_5678;
    step(); set_ra(5'd0, 5'd2);
    expect_both("we0_rd", K_RD, 1, 32'h0);

    // Issue every register 1..31 (reg 7 is a re-issue)
    for (int i = 1; i < NR; i++) begin
      step(); iv = 1'b1; ia = AW'(i);
    end
    step(); set_ra(5'd7, 5'd31);
    expect_both("full_cnt", K_CNT, 0, 32'd31);
    expect_both("full_bsy0", K_BSY, 0, 32'h1);
    expect_both("full_bsy1", K_BSY, 1, 32'h1);
    expect_both("full_rd0", K_RD, 0, 32'hA5A5_0000);

    // Asynchronous reset mid-cycle: everything reads zero before the next edge
    step(); set_ra(5'd7, 5'd4);
    expect_both("arst_cnt", K_CNT, 0, 32'h0);
    expect_both("arst_rd0", K_RD, 0, 32'h0);
    expect_both("arst_rd1", K_RD, 1, 32'h0);
    expect_both("arst_bsy0", K_BSY, 0, 32'h0);
    expect_both("arst_bsy1", K_BSY, 1, 32'h0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); set_ra(5'd3, 5'd31);
    expect_both("post_rd0", K_RD, 0, 32'h0);
    expect_both("post_bsy1", K_BSY, 1, 32'h0);
    expect_both("post_cnt", K_CNT, 0, 32'h0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
